// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - IFU/LSU request-response bundle and shared pmem port
interface mem_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int MASK_WIDTH = 8
);
   logic                  ifu_req_valid;
   logic                  ifu_req_ready;
   logic [DATA_WIDTH-1:0] ifu_addr;
   logic                  ifu_resp_valid;
   logic [DATA_WIDTH-1:0] ifu_rdata;

   logic                  lsu_req_valid;
   logic                  lsu_req_ready;
   logic [DATA_WIDTH-1:0] lsu_addr;
   logic                  lsu_wen;
   logic [DATA_WIDTH-1:0] lsu_wdata;
   logic [MASK_WIDTH-1:0] lsu_wmask;
   logic                  lsu_resp_valid;
   logic [DATA_WIDTH-1:0] lsu_rdata;

   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic [DATA_WIDTH-1:0] mem_addr;
   logic                  mem_wen;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [MASK_WIDTH-1:0] mem_wmask;
   logic                  mem_resp_valid;
   logic [DATA_WIDTH-1:0] mem_rdata;

   // Arbiter side: takes requests and memory responses, drives grants and the pmem request
   modport slave (
      input  ifu_req_valid, ifu_addr,
      input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
      input  mem_req_ready, mem_resp_valid, mem_rdata,
      output ifu_req_ready, ifu_resp_valid, ifu_rdata,
      output lsu_req_ready, lsu_resp_valid, lsu_rdata,
      output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
   );

   // Environment side: requesters plus the memory model
   modport master (
      output ifu_req_valid, ifu_addr,
      output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
      output mem_req_ready, mem_resp_valid, mem_rdata,
      input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
      input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
      input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin IFU/LSU arbiter and sequencer for the single pmem port
module mem_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int MASK_WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t                state;
   logic                  owner_lsu;
   logic                  last_lsu;
   logic                  req_valid;
   logic [DATA_WIDTH-1:0] addr_q;
   logic                  wen_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [MASK_WIDTH-1:0] wmask_q;

   logic                  grant_ifu;
   logic                  grant_lsu;
   logic                  resp_fire;

   // Grant in IDLE: a lone requester wins, a tie goes to whoever was not served last
   always_comb begin
      grant_ifu = 1'b0;
      grant_lsu = 1'b0;
      if (state == IDLE) begin
         if (bus.ifu_req_valid && bus.lsu_req_valid) begin
            grant_ifu = last_lsu;
            grant_lsu = ~last_lsu;
         end else begin
            grant_ifu = bus.ifu_req_valid;
            grant_lsu = bus.lsu_req_valid;
         end
      end
   end

   // Readies are masked by rst so nothing is accepted while reset is held
   assign bus.ifu_req_ready = grant_ifu & ~rst;
   assign bus.lsu_req_ready = grant_lsu & ~rst;

   // Responses only count in WAIT; rdata is a pass-through, zeroed when not delivering
   assign resp_fire          = (state == WAIT) && bus.mem_resp_valid;
   assign bus.ifu_resp_valid = resp_fire & ~owner_lsu;
   assign bus.lsu_resp_valid = resp_fire & owner_lsu;
   assign bus.ifu_rdata      = bus.ifu_resp_valid ? bus.mem_rdata : '0;
   assign bus.lsu_rdata      = bus.lsu_resp_valid ? bus.mem_rdata : '0;

   assign bus.mem_req_valid  = req_valid;
   assign bus.mem_addr       = addr_q;
   assign bus.mem_wen        = wen_q;
   assign bus.mem_wdata      = wdata_q;
   assign bus.mem_wmask      = wmask_q;

   // Transaction sequencer: latch the grantee, hold the request until accepted, await the response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         owner_lsu <= 1'b0;
         last_lsu  <= 1'b1;
         req_valid <= 1'b0;
         addr_q    <= '0;
         wen_q     <= 1'b0;
         wdata_q   <= '0;
         wmask_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_ifu) begin
                  addr_q    <= bus.ifu_addr;
                  wen_q     <= 1'b0;
                  wdata_q   <= '0;
                  wmask_q   <= '0;
                  owner_lsu <= 1'b0;
                  last_lsu  <= 1'b0;
                  req_valid <= 1'b1;
                  state     <= REQ;
               end else if (grant_lsu) begin
                  addr_q    <= bus.lsu_addr;
                  wen_q     <= bus.lsu_wen;
                  wdata_q   <= bus.lsu_wdata;
                  wmask_q   <= bus.lsu_wmask;
                  owner_lsu <= 1'b1;
                  last_lsu  <= 1'b1;
                  req_valid <= 1'b1;
                  state     <= REQ;
               end
            end
            REQ: begin
               if (bus.mem_req_ready) begin
                  req_valid <= 1'b0;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (bus.mem_resp_valid) begin
                  state <= IDLE;
               end
            end
            default: begin
               req_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end
endmodule
